// File: rtl/axi_aw_decerr_sink.sv
// ---------------------------------------------------------------------------
// axi_aw_decerr_sink
//
// Per-master-side sink for write transactions whose AW address matched no
// slave rule. The block accepts the missed AW, drains and discards the
// matching W burst, then requests a single DECERR write response from the
// downstream B-channel allocator. The error transaction is only started
// once no legitimate write is outstanding, which preserves AXI write
// response ordering for the master.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   awid_i/awuser_i       AW ID / USER of the missed transaction
//   awlen_i               AW burst length minus one
//   awvalid_i             AW valid
//   decode_miss_i         decoder flag: current AW matches no slave
//   awready_o             AW accepted by this block
//   wlast_i/wvalid_i      W channel routed to this block
//   wready_o              W accept (high throughout the drain phase)
//   w_route_busy_i        W router still carrying earlier legitimate beats
//   outstanding_trans_i   B allocator has legitimate responses pending
//   error_req_o           request the DECERR response
//   error_gnt_i           B allocator is emitting the error response
//   bready_i              master B ready, completes the error response
//   error_id_o            ID of the error response
//   error_user_o          USER of the error response
//   sample_awdata_info_o  one-cycle strobe to latch error_id_o/error_user_o
//   busy_o                an error transaction is in progress
//   proto_err_o           sticky: W beat count did not match awlen
//   err_count_o           completed DECERR transactions, saturating
// ---------------------------------------------------------------------------
module axi_aw_decerr_sink #(
   parameter int unsigned AXI_ID_IN  = 16,
   parameter int unsigned AXI_USER_W = 6,
   parameter int unsigned AXI_LEN_W  = 8,
   parameter int unsigned ERR_CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // AW side, from the address decoder
   input  logic [AXI_ID_IN-1:0]  awid_i,
   input  logic [AXI_USER_W-1:0] awuser_i,
   input  logic [AXI_LEN_W-1:0]  awlen_i,
   input  logic                  awvalid_i,
   input  logic                  decode_miss_i,
   output logic                  awready_o,
   // W side, from the W router
   input  logic                  wlast_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   input  logic                  w_route_busy_i,
   // B-channel allocator interface
   input  logic                  outstanding_trans_i,
   output logic                  error_req_o,
   input  logic                  error_gnt_i,
   input  logic                  bready_i,
   output logic [AXI_ID_IN-1:0]  error_id_o,
   output logic [AXI_USER_W-1:0] error_user_o,
   output logic                  sample_awdata_info_o,
   // status
   output logic                  busy_o,
   output logic                  proto_err_o,
   output logic [ERR_CNT_W-1:0]  err_count_o
);

   // Beat counter carries one extra bit so that overlong bursts are
   // distinguishable from a legal final beat before it saturates.
   localparam int unsigned BEAT_W = AXI_LEN_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_ERR_REQ = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [AXI_ID_IN-1:0]   id_q, id_d;
   logic [AXI_USER_W-1:0]  user_q, user_d;
   logic [AXI_LEN_W-1:0]   len_q, len_d;
   logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic                   proto_err_q, proto_err_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic                   awready_c;
   logic                   wready_c;
   logic                   error_req_c;
   logic                   sample_c;
   logic                   beat_at_len_c;

   // The current beat is the one the AW length announced as the last.
   assign beat_at_len_c = (beat_cnt_q == {1'b0, len_q});

   // State and payload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         id_q        <= '0;
         user_q      <= '0;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         proto_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         user_q      <= user_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         proto_err_q <= proto_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Next-state and handshake logic.
   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      user_d      = user_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      proto_err_d = proto_err_q;
      err_cnt_d   = err_cnt_q;
      awready_c   = 1'b0;
      wready_c    = 1'b0;
      error_req_c = 1'b0;
      sample_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Hold the missed AW back until every earlier legitimate write
            // has drained its W beats and returned its response. The reset
            // term keeps the handshake quiet while rst_n is asserted.
            awready_c = rst_n & decode_miss_i & ~w_route_busy_i
                        & ~outstanding_trans_i;
            if (awvalid_i && awready_c) begin
               id_d       = awid_i;
               user_d     = awuser_i;
               len_d      = awlen_i;
               beat_cnt_d = '0;
               sample_c   = 1'b1;
               state_d    = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            wready_c = 1'b1;
            if (wvalid_i) begin
               if (beat_cnt_q != '1) begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
               // wlast must coincide exactly with the beat at index awlen;
               // an early wlast or a beat past awlen without wlast is flagged.
               if (wlast_i != beat_at_len_c) begin
                  proto_err_d = 1'b1;
               end
               if (wlast_i) begin
                  state_d = ST_ERR_REQ;
               end
            end
         end

         ST_ERR_REQ: begin
            // ID/USER registers are untouched here, so the allocator's copy
            // stays valid for the whole response, even across B stalls.
            error_req_c = 1'b1;
            if (error_gnt_i && bready_i) begin
               state_d = ST_IDLE;
               if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ID/USER are forwarded straight from the AW bus in the sample cycle so
   // the allocator can latch them on the strobe itself.
   assign error_id_o           = sample_c ? awid_i : id_q;
   assign error_user_o         = sample_c ? awuser_i : user_q;

   assign awready_o            = awready_c;
   assign wready_o             = wready_c;
   assign error_req_o          = error_req_c;
   assign sample_awdata_info_o = sample_c;
   assign busy_o               = (state_q != ST_IDLE);
   assign proto_err_o          = proto_err_q;
   assign err_count_o          = err_cnt_q;

endmodule

// File: tb/tb_axi_aw_decerr_sink.sv
// ---------------------------------------------------------------------------
// Testbench for axi_aw_decerr_sink: a stimulus process issues missed write
// transactions (directed cases then randomized ones) and pushes the expected
// responses into queues; a monitor process on the falling edge compares the
// DUT's sample strobe, error response and post-completion status to them.
// ---------------------------------------------------------------------------
module tb_axi_aw_decerr_sink;

   localparam int unsigned ID_W   = 16;
   localparam int unsigned USER_W = 6;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned CNT_W  = 16;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [USER_W-1:0] user;
      logic              proto;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ID_W-1:0]   awid_i = '0;
   logic [USER_W-1:0] awuser_i = '0;
   logic [LEN_W-1:0]  awlen_i = '0;
   logic              awvalid_i = 1'b0;
   logic              decode_miss_i = 1'b0;
   logic              awready_o;
   logic              wlast_i = 1'b0;
   logic              wvalid_i = 1'b0;
   logic              wready_o;
   logic              w_route_busy_i = 1'b0;
   logic              outstanding_trans_i = 1'b0;
   logic              error_req_o;
   logic              error_gnt_i = 1'b0;
   logic              bready_i = 1'b0;
   logic [ID_W-1:0]   error_id_o;
   logic [USER_W-1:0] error_user_o;
   logic              sample_awdata_info_o;
   logic              busy_o;
   logic              proto_err_o;
   logic [CNT_W-1:0]  err_count_o;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   exp_t aw_q[$];
   exp_t cpl_q[$];
   exp_t mon_e;
   exp_t mon_exp;
   logic mon_pend = 1'b0;

   // reference model state: completed-error count and sticky protocol flag
   logic [CNT_W-1:0] m_cnt = '0;
   logic             m_proto = 1'b0;

   always #5 clk = ~clk;

   axi_aw_decerr_sink #(
      .AXI_ID_IN (ID_W),
      .AXI_USER_W(USER_W),
      .AXI_LEN_W (LEN_W),
      .ERR_CNT_W (CNT_W)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .awid_i              (awid_i),
      .awuser_i            (awuser_i),
      .awlen_i             (awlen_i),
      .awvalid_i           (awvalid_i),
      .decode_miss_i       (decode_miss_i),
      .awready_o           (awready_o),
      .wlast_i             (wlast_i),
      .wvalid_i            (wvalid_i),
      .wready_o            (wready_o),
      .w_route_busy_i      (w_route_busy_i),
      .outstanding_trans_i (outstanding_trans_i),
      .error_req_o         (error_req_o),
      .error_gnt_i         (error_gnt_i),
      .bready_i            (bready_i),
      .error_id_o          (error_id_o),
      .error_user_o        (error_user_o),
      .sample_awdata_info_o(sample_awdata_info_o),
      .busy_o              (busy_o),
      .proto_err_o         (proto_err_o),
      .err_count_o         (err_count_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clk) begin
      if (mon_pend) begin
         check("err_count_after_cpl", 32'(err_count_o), 32'(mon_exp.cnt));
         check("proto_err_after_cpl", 32'(proto_err_o), 32'(mon_exp.proto));
         check("idle_after_cpl", 32'(busy_o), 32'd0);
         mon_pend = 1'b0;
      end
      if (rst_n) begin
         if (sample_awdata_info_o) begin
            if (aw_q.size() == 0) begin
               check("unexpected_sample", 32'd1, 32'd0);
            end else begin
               mon_e = aw_q.pop_front();
               check("sample_id", 32'(error_id_o), 32'(mon_e.id));
               check("sample_user", 32'(error_user_o), 32'(mon_e.user));
            end
         end
         if (error_req_o) begin
            if (cpl_q.size() == 0) begin
               check("unexpected_error_req", 32'd1, 32'd0);
            end else begin
               mon_e = cpl_q[0];
               check("err_id", 32'(error_id_o), 32'(mon_e.id));
               check("err_user", 32'(error_user_o), 32'(mon_e.user));
               if (error_gnt_i && bready_i) begin
                  void'(cpl_q.pop_front());
                  mon_exp  = mon_e;
                  mon_pend = 1'b1;
               end
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_awready"}, 32'(awready_o), 32'd0);
      check({tag, "_wready"}, 32'(wready_o), 32'd0);
      check({tag, "_error_req"}, 32'(error_req_o), 32'd0);
      check({tag, "_sample"}, 32'(sample_awdata_info_o), 32'd0);
      check({tag, "_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_proto_err"}, 32'(proto_err_o), 32'd0);
      check({tag, "_err_count"}, 32'(err_count_o), 32'd0);
      check({tag, "_error_id"}, 32'(error_id_o), 32'd0);
      check({tag, "_error_user"}, 32'(error_user_o), 32'd0);
   endtask

   // One missed write. nblk cycles of blocking before the AW may be taken
   // (kind 0: outstanding responses, 1: W router busy, 2: decode hit).
   // hold_gnt > 0 stalls B for that many granted cycles. rst_after >= 0
   // asserts reset after that many W beats and abandons the transaction.
   task automatic do_txn(input logic [ID_W-1:0] id, input logic [USER_W-1:0] user,
                         input logic [LEN_W-1:0] len, input int nbeats, input int nblk,
                         input int kind, input int hold_gnt, input int rst_after);
      exp_t e;
      logic pe;
      pe = (nbeats != int'(len) + 1);
      if (rst_after < 0) begin
         m_proto = m_proto | pe;
         if (m_cnt != '1) m_cnt = m_cnt + 16'd1;
      end
      e.id = id; e.user = user; e.proto = m_proto; e.cnt = m_cnt;
      aw_q.push_back(e);
      if (rst_after < 0) cpl_q.push_back(e);

      // AW phase
      awid_i = id; awuser_i = user; awlen_i = len; awvalid_i = 1'b1;
      for (int c = 0; c <= nblk; c++) begin
         decode_miss_i       = !(c < nblk && kind == 2);
         outstanding_trans_i = (c < nblk && kind == 0);
         w_route_busy_i      = (c < nblk && kind == 1);
         @(negedge clk);
         check("awready_idle", 32'(awready_o), 32'(c == nblk));
         @(posedge clk); #1;
      end
      awvalid_i = 1'b0; outstanding_trans_i = 1'b0; w_route_busy_i = 1'b0;
      decode_miss_i = 1'b1;
      awid_i = ID_W'($urandom); awuser_i = USER_W'($urandom); awlen_i = LEN_W'($urandom);

      // W drain phase
      for (int b = 0; b < nbeats; b++) begin
         if (rst_after == b) begin
            rst_n = 1'b0; wvalid_i = 1'b0; wlast_i = 1'b0; awvalid_i = 1'b1;
            #1;
            check_all_zero("rst_mid");
            m_cnt = '0; m_proto = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            awvalid_i = 1'b0;
            rst_n = 1'b1;
            @(posedge clk); #1;
            return;
         end
         repeat ($urandom_range(0, 2)) begin
            wvalid_i = 1'b0; awvalid_i = 1'($urandom);
            @(negedge clk);
            check("awready_drain", 32'(awready_o), 32'd0);
            @(posedge clk); #1;
         end
         awvalid_i = 1'b0;
         wvalid_i = 1'b1; wlast_i = (b == nbeats - 1);
         @(negedge clk);
         check("wready_drain", 32'(wready_o), 32'd1);
         @(posedge clk); #1;
      end
      wvalid_i = 1'b0; wlast_i = 1'b0;

      // Error response phase
      for (int c = 0; c < 300; c++) begin
         awvalid_i = 1'($urandom); awid_i = ID_W'($urandom);
         if (hold_gnt > 0) begin
            error_gnt_i = 1'b1; bready_i = (c >= hold_gnt);
         end else begin
            error_gnt_i = ($urandom_range(0, 2) != 0); bready_i = 1'($urandom);
         end
         @(negedge clk);
         check("error_req", 32'(error_req_o), 32'd1);
         check("awready_err", 32'(awready_o), 32'd0);
         @(posedge clk); #1;
         if (error_gnt_i && bready_i) break;
      end
      error_gnt_i = 1'b0; bready_i = 1'b0; awvalid_i = 1'b0;
   endtask

   initial begin
      logic [LEN_W-1:0] len;
      int nb;
      // reset state, with a missed AW already presented
      awvalid_i = 1'b1; decode_miss_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      awvalid_i = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_txn(16'h01A5, 6'h2B, 8'd3, 4, 0, 0, 0, -1);           // single miss
      do_txn(16'h7001, 6'h11, 8'd2, 3, 5, 0, 0, -1);           // outstanding for 5 cycles
      do_txn(16'h0042, 6'h05, 8'd1, 2, 3, 1, 0, -1);           // W router busy
      do_txn(16'h0043, 6'h06, 8'd0, 1, 2, 2, 0, -1);           // decode hit, not taken
      do_txn(16'h0BAD, 6'h3F, 8'd3, 2, 0, 0, 0, -1);           // early wlast
      do_txn(16'h0BAE, 6'h01, 8'd0, 3, 0, 0, 0, -1);           // late wlast
      do_txn(16'hC0DE, 6'h2A, 8'd1, 2, 0, 0, 4, -1);           // B stall 4 cycles
      do_txn(16'h1111, 6'h0A, 8'd0, 1, 0, 0, 1, -1);           // back-to-back pair
      do_txn(16'h2222, 6'h0B, 8'd0, 1, 0, 0, 1, -1);
      do_txn(16'h3333, 6'h0C, 8'd7, 8, 0, 0, 0, 2);            // reset mid-drain
      do_txn(16'h4444, 6'h0D, 8'd2, 3, 0, 0, 0, -1);           // normal after reset

      for (int t = 0; t < 40; t++) begin
         len = LEN_W'($urandom_range(0, 5));
         nb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : int'(len) + 1;
         do_txn(ID_W'($urandom), USER_W'($urandom), len, nb,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, -1);
      end

      repeat (3) @(posedge clk);
      #1;
      check("aw_queue_drained", 32'(aw_q.size()), 32'd0);
      check("cpl_queue_drained", 32'(cpl_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
